matmul_engine: RTL and testbench

- Compute core directly downstream of apbslave. It consumes the operand_A/B/C buses and control_reg, and returns result, ov and EOP to apbslave.
- Performs C = A×B (+ bias) on signed DATA_WIDTH elements, matrices up to MAX_DIM×MAX_DIM.
- Uses a MAX_DIM×MAX_DIM accumulator array and processes one inner-dimension index k per cycle.
- Snapshots its operands at start, so apbslave may be rewritten while the engine is busy.

---
 rtl/matmul_engine.sv | 117 +++++++++++
 tb/tb_matmul_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// matmul_engine: signed matrix multiply-accumulate engine, C = A x B (+ bias), one inner index per cycle.
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   operand_A_i      A rows, one row per bus word, element k at DATA_WIDTH*k
//   operand_B_i      B rows, packed like A
//   operand_C_i      bias elements, element (i,j) at word i*MAX_DIM+j
//   control_reg_i    bit0 start, bit1 bias_en, [9:8] N-1, [11:10] K-1, [13:12] M-1
//   result_o, ov_o   masked result and sticky per-element overflow, held until next completion
//   EOP_o, busy_o    end-of-operation level, operation in progress
module matmul_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH = 32,
   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH,
   localparam int NE = MAX_DIM * MAX_DIM
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [BUS_WIDTH*MAX_DIM-1:0] operand_A_i,
   input  logic [BUS_WIDTH*MAX_DIM-1:0] operand_B_i,
   input  logic [BUS_WIDTH*NE-1:0] operand_C_i,
   input  logic [15:0]             control_reg_i,
   output logic [BUS_WIDTH*NE-1:0] result_o,
   output logic [NE-1:0]           ov_o,
   output logic                    EOP_o,
   output logic                    busy_o
);
   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;
   state_t state_q;
   logic start_q;
   logic start_w;
   logic [BUS_WIDTH*MAX_DIM-1:0] a_q, b_q;
   logic [1:0] n_q, kd_q, m_q, k_q;
   logic [BUS_WIDTH-1:0] acc_q [NE];
   logic [BUS_WIDTH-1:0] acc_d [NE];
   logic [BUS_WIDTH-1:0] init_w [NE];
   logic [NE-1:0] ovf_q, ovf_d, in_w;
   logic [BUS_WIDTH*NE-1:0] result_q, res_w;
   logic [NE-1:0] ov_q;
   logic eop_q, busy_q;
   assign start_w = (state_q == IDLE) && control_reg_i[0] && !start_q;
   for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
      for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
         localparam int E = i * MAX_DIM + j;
         logic signed [DATA_WIDTH-1:0] a_e, b_e;
         logic signed [2*DATA_WIDTH-1:0] prod;
         logic [BUS_WIDTH-1:0] ext, sum;
         assign a_e = a_q[BUS_WIDTH*i + DATA_WIDTH*int'(k_q) +: DATA_WIDTH];
         assign b_e = b_q[BUS_WIDTH*int'(k_q) + DATA_WIDTH*j +: DATA_WIDTH];
         assign prod = a_e * b_e;
         assign ext = {{(BUS_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
         assign sum = acc_q[E] + ext;
         assign acc_d[E] = sum;
         // overflow: like-signed addends producing a sum of the opposite sign
         assign ovf_d[E] = ovf_q[E] | ((acc_q[E][BUS_WIDTH-1] == ext[BUS_WIDTH-1]) &
                                       (sum[BUS_WIDTH-1] != acc_q[E][BUS_WIDTH-1]));
         assign in_w[E] = (2'(i) <= n_q) && (2'(j) <= m_q);
         assign init_w[E] = control_reg_i[1] ? operand_C_i[BUS_WIDTH*E +: BUS_WIDTH] : '0;
         assign res_w[BUS_WIDTH*E +: BUS_WIDTH] = in_w[E] ? acc_q[E] : '0;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         n_q      <= '0;
         kd_q     <= '0;
         m_q      <= '0;
         k_q      <= '0;
         ovf_q    <= '0;
         result_q <= '0;
         ov_q     <= '0;
         eop_q    <= 1'b0;
         busy_q   <= 1'b0;
         for (int e = 0; e < NE; e++) acc_q[e] <= '0;
      end else begin
         start_q <= control_reg_i[0];
         case (state_q)
            IDLE: if (start_w) begin
               state_q <= LOAD;
               busy_q  <= 1'b1;
               eop_q   <= 1'b0;
            end
            LOAD: begin
               a_q   <= operand_A_i;
               b_q   <= operand_B_i;
               n_q   <= control_reg_i[9:8];
               kd_q  <= control_reg_i[11:10];
               m_q   <= control_reg_i[13:12];
               ovf_q <= '0;
               k_q   <= '0;
               for (int e = 0; e < NE; e++) acc_q[e] <= init_w[e];
               state_q <= COMPUTE;
            end
            COMPUTE: begin
               for (int e = 0; e < NE; e++) acc_q[e] <= acc_d[e];
               ovf_q <= ovf_d;
               if (k_q == kd_q) state_q <= DONE;
               else k_q <= k_q + 1'b1;
            end
            DONE: begin
               result_q <= res_w;
               ov_q     <= ovf_q & in_w;
               eop_q    <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign result_o = result_q;
   assign ov_o = ov_q;
   assign EOP_o = eop_q;
   assign busy_o = busy_q;
endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: directed and random checks of matmul_engine against an arithmetic reference model.
module tb_matmul_engine;
   logic clk_i = 1'b0;
   logic rst_n_i;
   logic [127:0] operand_A_i, operand_B_i;
   logic [511:0] operand_C_i;
   logic [15:0] control_reg_i;
   logic [511:0] result_o;
   logic [15:0] ov_o;
   logic EOP_o, busy_o;
   int checks = 0;
   int errors = 0;
   logic [7:0] am [4][4];
   logic [7:0] bm [4][4];
   logic [31:0] cm [4][4];
   logic [511:0] exp_res;
   logic [15:0] exp_ov;
   matmul_engine dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .operand_A_i(operand_A_i), .operand_B_i(operand_B_i),
      .operand_C_i(operand_C_i), .control_reg_i(control_reg_i), .result_o(result_o),
      .ov_o(ov_o), .EOP_o(EOP_o), .busy_o(busy_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic pack();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            operand_A_i[32*i+8*j +: 8] = am[i][j];
            operand_B_i[32*i+8*j +: 8] = bm[i][j];
            operand_C_i[32*(4*i+j) +: 32] = cm[i][j];
         end
   endtask
   task automatic fill_seq(input logic [31:0] bias);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            am[i][j] = 8'(4*i + j + 1);
            bm[i][j] = 8'(4*i + j + 1);
            cm[i][j] = bias;
         end
   endtask
   task automatic fill_rand();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            am[i][j] = 8'($urandom);
            bm[i][j] = 8'($urandom);
            cm[i][j] = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FF00 + 32'($urandom_range(0, 255)) : 32'($urandom);
         end
   endtask
   // exact 64-bit accumulation; an addition overflows when truncation to 32 bits changes its value
   function automatic void run_model(input int n, input int k, input int m, input bit bias);
      longint acc, s;
      int p;
      bit o;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = bias ? longint'($signed(cm[i][j])) : 64'sd0;
            o = 1'b0;
            for (int kk = 0; kk < k; kk++) begin
               p = int'($signed(am[i][kk])) * int'($signed(bm[kk][j]));
               s = acc + longint'(p);
               if (s != longint'(int'(s))) o = 1'b1;
               acc = longint'(int'(s));
            end
            exp_res[32*(4*i+j) +: 32] = (i < n && j < m) ? 32'(acc) : 32'd0;
            exp_ov[4*i+j] = (i < n && j < m) ? o : 1'b0;
         end
   endfunction
   task automatic op(input logic [15:0] ctrl, input string tag);
      int edges;
      int k;
      k = int'(ctrl[11:10]) + 1;
      run_model(int'(ctrl[9:8]) + 1, k, int'(ctrl[13:12]) + 1, ctrl[1]);
      pack();
      control_reg_i = ctrl & 16'hFFFE;
      @(negedge clk_i);
      control_reg_i = ctrl;
      @(negedge clk_i);
      edges = 0;
      chk({tag, " busy"}, busy_o, 1'b1);
      chk({tag, " eop_clr"}, EOP_o, 1'b0);
      while (EOP_o !== 1'b1 && edges < 20) begin
         @(negedge clk_i);
         edges++;
      end
      chk({tag, " latency"}, edges, k + 2);
      chk({tag, " result"}, result_o, exp_res);
      chk({tag, " ov"}, ov_o, exp_ov);
      chk({tag, " busy_end"}, busy_o, 1'b0);
   endtask
   initial begin
      int edges;
      rst_n_i = 1'b0;
      control_reg_i = '0;
      operand_A_i = '0;
      operand_B_i = '0;
      operand_C_i = '0;
      repeat (2) @(negedge clk_i);
      chk("rst result", result_o, 512'd0);
      chk("rst ov", ov_o, 16'd0);
      chk("rst eop", EOP_o, 1'b0);
      chk("rst busy", busy_o, 1'b0);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      fill_seq(32'd0);
      op(16'h3F01, "full");
      chk("full c00", result_o[31:0], 32'd90);
      chk("full c01", result_o[63:32], 32'd100);
      chk("full c33", result_o[32*15 +: 32], 32'd600);
      fill_seq(32'd10);
      op(16'h3F03, "bias");
      chk("bias c00", result_o[31:0], 32'd100);
      chk("bias c33", result_o[32*15 +: 32], 32'd610);
      fill_seq(32'd0);
      op(16'h2501, "reduced");
      chk("reduced c00", result_o[31:0], 32'd11);
      chk("reduced c12", result_o[32*6 +: 32], 32'd57);
      chk("reduced c03", result_o[32*3 +: 32], 32'd0);
      chk("reduced rows23", result_o[511:256], 256'd0);
      fill_seq(32'd0);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            am[i][j] = 8'd0;
            bm[i][j] = 8'd0;
         end
      am[0][0] = 8'hFF;
      bm[0][0] = 8'h02;
      op(16'h0001, "signed");
      chk("signed c00", result_o[31:0], 32'hFFFF_FFFE);
      am[0][0] = 8'h01;
      bm[0][0] = 8'h01;
      cm[0][0] = 32'h7FFF_FFFF;
      op(16'h0003, "ovf");
      chk("ovf c00", result_o[31:0], 32'h8000_0000);
      chk("ovf bits", ov_o, 16'h0001);
      fill_rand();
      run_model(4, 4, 4, 1'b0);
      pack();
      control_reg_i = 16'h3F00;
      @(negedge clk_i);
      control_reg_i = 16'h3F01;
      repeat (2) @(negedge clk_i);
      control_reg_i = 16'h3F00;
      operand_A_i = {4{32'($urandom)}};
      operand_B_i = {4{32'($urandom)}};
      @(negedge clk_i);
      control_reg_i = 16'h3F01;
      edges = 2;
      while (EOP_o !== 1'b1 && edges < 20) begin
         @(negedge clk_i);
         edges++;
      end
      chk("busystart latency", edges, 6);
      chk("busystart result", result_o, exp_res);
      repeat (6) @(negedge clk_i);
      chk("busystart single eop", EOP_o, 1'b1);
      chk("busystart idle", busy_o, 1'b0);
      for (int t = 0; t < 6; t++) begin
         fill_rand();
         op((16'($urandom) & 16'hC0FC) | (16'($urandom) & 16'h3F02) | 16'h0001, "random");
      end
      fill_seq(32'd0);
      pack();
      control_reg_i = 16'h3F00;
      @(negedge clk_i);
      control_reg_i = 16'h3F01;
      repeat (3) @(negedge clk_i);
      rst_n_i = 1'b0;
      control_reg_i = 16'h3F00;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      chk("midrst result", result_o, 512'd0);
      chk("midrst ov", ov_o, 16'd0);
      chk("midrst eop", EOP_o, 1'b0);
      chk("midrst busy", busy_o, 1'b0);
      repeat (10) @(negedge clk_i);
      chk("midrst no eop", EOP_o, 1'b0);
      op(16'h3F01, "after rst");
      chk("after rst c33", result_o[32*15 +: 32], 32'd600);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
